// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage entry type and constants
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two prefetch FIFO of {pc, instr} with flush priority
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with 1-cycle ROM, prefetch FIFO and redirect flush
module fetch_unit import fetch_pkg::*; #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fetch_pc, inflight_pc;
  logic inflight, kill;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head;
  assign occ       = (CW+1)'(count) + (CW+1)'(inflight);
  assign imem_req  = rst & ~redirect & (occ < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign out_valid = count != '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc    <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + INSTR_BYTES;
        inflight_pc <= fetch_pc;
      end else if (redirect) fetch_pc <= redirect_pc & ~32'h3;
      kill <= redirect ? inflight : (imem_req ? 1'b0 : kill);
    end
  // space for the in-flight word is reserved by the request condition, so pushes never overflow
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (inflight & ~kill),
    .pop   (out_valid & out_ready),
    .din   ('{pc: inflight_pc, instr: imem_rdata}),
    .dout  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed corner sequences and a queue-based random model
module tb_fetch_unit;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [31:0] m_fetch = 32'h0;
  logic [31:0] m_fly_pc = 32'h0;
  logic m_fly = 1'b0;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  typedef struct {
    logic        rd;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[16];

  fetch_unit #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) if (imem_req) imem_rdata <= rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fly = 1'b0;
    m_fetch = 32'h0;
  endtask

  task automatic step(input logic rd, input logic rdr, input logic [31:0] rpc);
    int n;
    logic ereq;
    out_ready = rd;
    redirect = rdr;
    redirect_pc = rpc;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc; s_instr = out_instr;
    n = q.size();
    ereq = !rdr && (n + int'(m_fly) < DEPTH);
    chk("imem_req", 32'(s_req), 32'(ereq));
    chk("imem_addr", s_addr, m_fetch);
    chk("out_valid", 32'(s_valid), 32'(n != 0));
    if (n != 0) begin
      chk("out_pc", s_pc, q[0]);
      chk("out_instr", s_instr, rom(q[0]));
    end else begin
      chk("out_pc_empty", s_pc, 32'h0);
      chk("out_instr_empty", s_instr, 32'h0);
    end
    @(posedge clk);
    if (rdr) begin
      q.delete();
      m_fly = 1'b0;
      m_fetch = rpc & 32'hFFFF_FFFC;
    end else begin
      if (n != 0 && rd) void'(q.pop_front());
      if (m_fly) q.push_back(m_fly_pc);
      m_fly = ereq;
      if (ereq) begin
        m_fly_pc = m_fetch;
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{0, 1, 0,  0, 0};
    tbl[1]  = '{0, 1, 4,  0, 0};
    tbl[2]  = '{0, 1, 8,  1, 0};
    tbl[3]  = '{0, 1, 12, 1, 0};
    for (int i = 4; i < 10; i++) tbl[i] = '{0, 0, 16, 1, 0};
    tbl[10] = '{1, 0, 16, 1, 0};
    tbl[11] = '{1, 1, 16, 1, 4};
    tbl[12] = '{1, 1, 20, 1, 8};
    tbl[13] = '{1, 1, 24, 1, 12};
    tbl[14] = '{1, 1, 28, 1, 16};
    tbl[15] = '{1, 1, 32, 1, 20};
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rd, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].valid ? rom(tbl[i].pc) : 32'h0);
    end
    // redirect while holding three entries with a fourth in flight
    for (int i = 0; i < 12 && !(q.size() == 3 && m_fly); i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0101);
    chk("redir_empty", 32'(out_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_n1_valid", 32'(out_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_n2_valid", 32'(out_valid), 32'h1);
    chk("redir_n2_pc", out_pc, 32'h0000_0100);
    // consecutive redirects: only the last target is fetched
    step(1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b1, 32'h80);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("dbl_redir_pc", out_pc, 32'h80);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // address wrap at the top of the space
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap0", out_pc, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap1", out_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap2", out_pc, 32'h0);
    chk("wrap2_instr", out_instr, 32'h0);
    // asynchronous reset between edges mid-stream
    repeat (3) step(1'b0, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_req", 32'(imem_req), 32'h0);
    chk("async_pc", out_pc, 32'h0);
    chk("async_instr", out_instr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("post_rst_pc", out_pc, 32'h0);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      logic rd, rdr;
      logic [31:0] rpc;
      rd = $urandom_range(0, 3) != 0;
      rdr = $urandom_range(0, 15) == 0;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(rd, rdr, rpc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
